// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues word-aligned imem requests under a credit limit,
// buffers PC-tagged responses in a FIFO and drops in-flight responses after a flush.
module instr_fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_i,
    input  logic             pc_valid_i,
    output logic             pc_ready_o,
    input  logic             flush_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [WIDTH-1:0] imem_rdata_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_instr_o,
    output logic [WIDTH-1:0] out_pc_o,
    input  logic             out_ready_i,
    output logic             err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] pend_mem  [DEPTH];
    logic [WIDTH-1:0] fifo_pc   [DEPTH];
    logic [WIDTH-1:0] fifo_inst [DEPTH];

    logic [AW-1:0] pw_q, pw_d, pr_q, pr_d, fw_q, fw_d, fr_q, fr_d;
    logic [CW-1:0] outst_q, outst_d, cnt_q, cnt_d, drop_q, drop_d;
    logic          err_q, err_d;

    logic credit, accept, rsp, spurious, push, pop;

    // Credit covers both buffered and in-flight entries so a response always has a slot.
    assign credit     = ({1'b0, outst_q} + {1'b0, cnt_q}) < (CW+1)'(DEPTH);
    assign imem_req_o = pc_valid_i & credit & ~flush_i & ~rst;
    assign accept     = imem_req_o & imem_gnt_i;
    assign pc_ready_o = accept;
    assign imem_addr_o = {pc_i[WIDTH-1:2], 2'b00};

    assign rsp      = imem_rvalid_i & (outst_q != '0);
    assign spurious = imem_rvalid_i & (outst_q == '0);
    assign push     = rsp & ~flush_i & (drop_q == '0);
    assign pop      = out_valid_o & out_ready_i & ~flush_i;

    assign out_valid_o = (cnt_q != '0);
    assign out_instr_o = fifo_inst[fr_q];
    assign out_pc_o    = fifo_pc[fr_q];
    assign err_o       = err_q;

    always_comb begin
        pw_d    = pw_q + AW'(accept);
        pr_d    = pr_q + AW'(rsp);
        outst_d = outst_q + CW'(accept) - CW'(rsp);
        fw_d    = fw_q + AW'(push);
        fr_d    = fr_q + AW'(pop);
        cnt_d   = cnt_q + CW'(push) - CW'(pop);
        drop_d  = drop_q;
        if (rsp && drop_q != '0)
            drop_d = drop_q - CW'(1);
        err_d   = err_q | spurious;
        // Everything still in flight after this cycle belongs to the wrong path.
        if (flush_i) begin
            fr_d   = fw_q;
            cnt_d  = '0;
            drop_d = outst_q - CW'(rsp);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pw_q    <= '0;
            pr_q    <= '0;
            fw_q    <= '0;
            fr_q    <= '0;
            outst_q <= '0;
            cnt_q   <= '0;
            drop_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            pw_q    <= pw_d;
            pr_q    <= pr_d;
            fw_q    <= fw_d;
            fr_q    <= fr_d;
            outst_q <= outst_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            pend_mem[pw_q] <= pc_i;
        if (push) begin
            fifo_pc[fw_q]   <= pend_mem[pr_q];
            fifo_inst[fw_q] <= imem_rdata_i;
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a latency-programmable memory model feeds the DUT,
// stimulus pushes hand-chosen expected {pc, instr} pairs, a monitor pops and compares.
module tb_instr_fetch_queue;
    logic        clk, rst;
    logic [31:0] pc_i;
    logic        pc_valid_i, pc_ready_o, flush_i;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic        out_valid_o, out_ready_i, err_o;
    logic [31:0] out_instr_o, out_pc_o;

    instr_fetch_queue #(.WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
        .flush_i(flush_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .out_valid_o(out_valid_o), .out_instr_o(out_instr_o), .out_pc_o(out_pc_o),
        .out_ready_i(out_ready_i), .err_o(err_o)
    );

    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    exp_t  exp_q[$];
    mreq_t mq[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    mem_lat = 1;
    logic  mem_rv, spur;
    logic [31:0] mem_rd;

    assign imem_rvalid_i = mem_rv | spur;
    assign imem_rdata_i  = mem_rd;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rdat(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    task automatic nx;
        @(posedge clk);
        #1;
    endtask

    task automatic ne;
        @(negedge clk);
    endtask

    task automatic expect_fetch(input logic [31:0] pc, input logic [31:0] addr);
        exp_q.push_back('{pc: pc, instr: rdat(addr)});
    endtask

    task automatic drain;
        int n;
        n = 0;
        pc_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        while (exp_q.size() != 0 && n < 40) begin
            nx;
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'h0);
        nx;
        nx;
    endtask

    // Memory: in-order responses mem_lat cycles after the grant cycle.
    initial begin
        mem_rv = 1'b0;
        mem_rd = '0;
        forever begin
            @(negedge clk);
            if (rst)
                mq.delete();
            else if (imem_req_o && imem_gnt_i)
                mq.push_back('{addr: imem_addr_o, due: cyc + mem_lat});
            @(posedge clk);
            #1;
            mem_rv = 1'b0;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                mem_rv = 1'b1;
                mem_rd = rdat(mq[0].addr);
                void'(mq.pop_front());
            end
        end
    end

    // Monitor: every accepted output must match the next expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && !flush_i && out_valid_o && out_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: got pc %h instr %h, expected no output", out_pc_o, out_instr_o);
                end else begin
                    e = exp_q.pop_front();
                    if (out_pc_o !== e.pc || out_instr_o !== e.instr) begin
                        errors++;
                        $display("FAIL out_entry: got pc %h instr %h, expected pc %h instr %h",
                                 out_pc_o, out_instr_o, e.pc, e.instr);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pc_i = 32'h40; pc_valid_i = 1'b1; flush_i = 1'b0;
        imem_gnt_i = 1'b1; out_ready_i = 1'b1; spur = 1'b0;

        // Reset state, with a valid PC offered.
        nx; ne;
        chkb("rst_out_valid", out_valid_o, 1'b0);
        chkb("rst_err", err_o, 1'b0);
        chkb("rst_req", imem_req_o, 1'b0);
        chkb("rst_ready", pc_ready_o, 1'b0);
        nx; ne;
        chkb("rst_req_held", imem_req_o, 1'b0);
        nx;

        // Streaming with single-cycle memory.
        rst = 1'b0; mem_lat = 1;
        for (int i = 0; i < 8; i++) begin
            pc_i = 32'(4 * i); pc_valid_i = 1'b1;
            ne;
            chkb("stream_ready", pc_ready_o, 1'b1);
            chk("stream_addr", imem_addr_o, 32'(4 * i));
            if (i >= 2) chkb("stream_out_valid", out_valid_o, 1'b1);
            if (i == 2) chk("stream_first_pc", out_pc_o, 32'h0);
            expect_fetch(32'(4 * i), 32'(4 * i));
            nx;
        end
        drain;

        // Unaligned PC: address is word-aligned, tag keeps the full PC.
        pc_i = 32'h43; pc_valid_i = 1'b1;
        ne;
        chk("unaligned_addr", imem_addr_o, 32'h40);
        chkb("unaligned_ready", pc_ready_o, 1'b1);
        expect_fetch(32'h43, 32'h40);
        nx;
        drain;

        // Back-pressure: exactly DEPTH accepts, then stall.
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc_i = 32'(4 * i); pc_valid_i = 1'b1;
            ne;
            chkb("bp_accept", pc_ready_o, 1'b1);
            expect_fetch(32'(4 * i), 32'(4 * i));
            nx;
        end
        pc_i = 32'h10;
        for (int i = 0; i < 3; i++) begin
            ne;
            chkb("bp_full_ready", pc_ready_o, 1'b0);
            chkb("bp_full_req", imem_req_o, 1'b0);
            nx;
        end
        out_ready_i = 1'b1;
        ne;
        chk("bp_pop_pc", out_pc_o, 32'h0);
        chkb("bp_pop_ready", pc_ready_o, 1'b0);
        nx;
        out_ready_i = 1'b0;
        ne;
        chkb("bp_regrant", pc_ready_o, 1'b1);
        expect_fetch(32'h10, 32'h10);
        nx;
        pc_i = 32'h14;
        ne;
        chkb("bp_refull", pc_ready_o, 1'b0);
        nx;
        drain;

        // Flush with two responses in flight and one buffered entry.
        mem_lat = 3; out_ready_i = 1'b0;
        pc_i = 32'h200; pc_valid_i = 1'b1;
        ne; chkb("fl_acc0", pc_ready_o, 1'b1); expect_fetch(32'h200, 32'h200); nx;
        pc_valid_i = 1'b0; nx; nx;
        pc_i = 32'h204; pc_valid_i = 1'b1;
        ne; chkb("fl_acc1", pc_ready_o, 1'b1); expect_fetch(32'h204, 32'h204); nx;
        pc_i = 32'h208;
        ne; chkb("fl_acc2", pc_ready_o, 1'b1); expect_fetch(32'h208, 32'h208); nx;
        pc_valid_i = 1'b0; flush_i = 1'b1;
        exp_q.delete();
        ne; chkb("fl_pre_valid", out_valid_o, 1'b1); chkb("fl_no_req", imem_req_o, 1'b0); nx;
        flush_i = 1'b0; pc_i = 32'h100; pc_valid_i = 1'b1; out_ready_i = 1'b1;
        ne; chkb("fl_post_valid", out_valid_o, 1'b0); chkb("fl_post_accept", pc_ready_o, 1'b1);
        expect_fetch(32'h100, 32'h100); nx;
        pc_valid_i = 1'b0;
        ne; chkb("fl_drop1", out_valid_o, 1'b0); nx;
        ne; chkb("fl_drop2", out_valid_o, 1'b0); nx;
        drain;

        // Flush coinciding with a response and a pop.
        mem_lat = 1; out_ready_i = 1'b1;
        pc_i = 32'h300; pc_valid_i = 1'b1;
        ne; chkb("fr_acc0", pc_ready_o, 1'b1); expect_fetch(32'h300, 32'h300); nx;
        pc_i = 32'h304;
        ne; chkb("fr_acc1", pc_ready_o, 1'b1); expect_fetch(32'h304, 32'h304); nx;
        pc_valid_i = 1'b0; flush_i = 1'b1;
        exp_q.delete();
        ne; chkb("fr_pre_valid", out_valid_o, 1'b1); nx;
        flush_i = 1'b0; pc_i = 32'h104; pc_valid_i = 1'b1;
        ne; chkb("fr_empty", out_valid_o, 1'b0); chkb("fr_accept", pc_ready_o, 1'b1);
        expect_fetch(32'h104, 32'h104); nx;
        pc_valid_i = 1'b0;
        ne; chkb("fr_empty2", out_valid_o, 1'b0); nx;
        drain;

        // Grant stall.
        imem_gnt_i = 1'b0; pc_i = 32'h20; pc_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ne;
            chkb("gs_req", imem_req_o, 1'b1);
            chk("gs_addr", imem_addr_o, 32'h20);
            chkb("gs_no_accept", pc_ready_o, 1'b0);
            nx;
        end
        imem_gnt_i = 1'b1;
        ne; chkb("gs_accept", pc_ready_o, 1'b1); expect_fetch(32'h20, 32'h20); nx;
        drain;

        // Spurious response with nothing outstanding.
        spur = 1'b1;
        nx;
        spur = 1'b0;
        ne; chkb("sp_err", err_o, 1'b1); chkb("sp_fifo_empty", out_valid_o, 1'b0); nx;
        nx;
        ne; chkb("sp_err_sticky", err_o, 1'b1); nx;
        rst = 1'b1;
        nx;
        ne; chkb("sp_rst_err", err_o, 1'b0); chkb("sp_rst_valid", out_valid_o, 1'b0); nx;
        rst = 1'b0;
        ne; chkb("sp_err_after_rst", err_o, 1'b0); nx;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
